// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared constants and bullet record for the player projectile pool
package player_pkg;

    localparam logic [9:0] SCREEN_W_MAX = 10'd639;
    localparam logic [7:0] FIRE_KEY     = 8'h0D;

    typedef struct packed {
        logic       active;
        logic       dir;
        logic [9:0] x;
        logic [9:0] y;
    } pbullet_t;

endpackage

// File: rtl/pbullet_slot.sv
// rtl/pbullet_slot.sv - one player bullet: kill, move/scroll, retire at screen edge, load on spawn
module pbullet_slot
    import player_pkg::*;
#(
    parameter int SPEED       = 8,
    parameter int SCROLL_STEP = 5
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       play,
    input  logic       kill,
    input  logic       scroll,
    input  logic       load,
    input  logic       load_dir,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    output pbullet_t   bullet
);

    pbullet_t          bullet_q, bullet_d;
    logic signed [11:0] nx;

    always_comb begin
        bullet_d = bullet_q;
        nx       = {2'b00, bullet_q.x};
        if (bullet_q.dir) nx = nx + 12'(SPEED);
        else              nx = nx - 12'(SPEED);
        if (scroll)       nx = nx - 12'(SCROLL_STEP);

        if (play) begin
            if (bullet_q.active) begin
                if (kill) begin
                    bullet_d.active = 1'b0;
                end else if (nx < 0 || nx > $signed({2'b00, SCREEN_W_MAX})) begin
                    bullet_d.active = 1'b0;
                end else begin
                    bullet_d.x = nx[9:0];
                end
            end else if (load) begin
                // spawn frame: position is loaded as-is, no movement applied
                bullet_d.active = 1'b1;
                bullet_d.dir    = load_dir;
                bullet_d.x      = load_x;
                bullet_d.y      = load_y;
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) bullet_q <= '0;
        else       bullet_q <= bullet_d;
    end

    assign bullet = bullet_q;

endmodule

// File: rtl/player_bullet.sv
// rtl/player_bullet.sv - player bullet pool top: slot allocation, cooldown, packing; PBULLET_STATS_EN adds shots_fired
module player_bullet
    import player_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int SPEED       = 8,
    parameter int SCROLL_STEP = 5,
    parameter int COOLDOWN    = 10,
    parameter int GUN_DX      = 20,
    parameter int GUN_DY      = 12
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      play,
    input  logic [7:0]                keycode,
    input  logic [9:0]                playerX,
    input  logic [9:0]                playerY,
    input  logic                      direction,
    input  logic                      scroll,
    input  logic [NUM_BULLETS-1:0]    hit_mask,
    output logic [10*NUM_BULLETS-1:0] bulletX,
    output logic [10*NUM_BULLETS-1:0] bulletY,
    output logic [NUM_BULLETS-1:0]    bullet_active,
    output logic [NUM_BULLETS-1:0]    bullet_dir
`ifdef PBULLET_STATS_EN
    ,
    output logic [15:0]               shots_fired
`endif
);

    pbullet_t               slots [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] free_vec, lowest_free, load_vec;
    logic                   found;
    logic signed [11:0]     spawn_x;
    logic [9:0]             spawn_y;
    logic                   fire_req, spawn;
    logic [15:0]            cd_q, cd_d;

    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) free_vec[i] = ~slots[i].active;
    end

    always_comb begin
        lowest_free = '0;
        found       = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (free_vec[i] && !found) begin
                lowest_free[i] = 1'b1;
                found          = 1'b1;
            end
        end
    end

    always_comb begin
        spawn_x = {2'b00, playerX};
        if (direction) spawn_x = spawn_x + 12'(GUN_DX);
        else           spawn_x = spawn_x - 12'(GUN_DX);
        spawn_y  = playerY + 10'(GUN_DY);
        fire_req = (keycode == FIRE_KEY) && (cd_q == '0);
        // an off-screen-left spawn is dropped without consuming the cooldown
        spawn    = play && fire_req && found && !(spawn_x < 0);
        load_vec = spawn ? lowest_free : '0;
    end

    always_comb begin
        cd_d = cd_q;
        if (play) begin
            if (spawn)             cd_d = 16'(COOLDOWN);
            else if (cd_q != '0)   cd_d = cd_q - 16'd1;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) cd_q <= '0;
        else       cd_q <= cd_d;
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        pbullet_slot #(
            .SPEED       (SPEED),
            .SCROLL_STEP (SCROLL_STEP)
        ) u_slot (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .play      (play),
            .kill      (hit_mask[g]),
            .scroll    (scroll),
            .load      (load_vec[g]),
            .load_dir  (direction),
            .load_x    (spawn_x[9:0]),
            .load_y    (spawn_y),
            .bullet    (slots[g])
        );

        assign bulletX[10*g +: 10] = slots[g].x;
        assign bulletY[10*g +: 10] = slots[g].y;
        assign bullet_active[g]    = slots[g].active;
        assign bullet_dir[g]       = slots[g].dir;
    end

`ifdef PBULLET_STATS_EN
    logic [15:0] shots_q, shots_d;

    always_comb begin
        shots_d = shots_q;
        if (spawn) shots_d = shots_q + 16'd1;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) shots_q <= '0;
        else       shots_q <= shots_d;
    end

    assign shots_fired = shots_q;
`endif

endmodule

// File: tb/tb_player_bullet.sv
// tb/tb_player_bullet.sv - directed self-checking bench for player_bullet
module tb_player_bullet;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic        play = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [9:0]  playerX = 10'd100;
    logic [9:0]  playerY = 10'd200;
    logic        direction = 1'b1;
    logic        scroll = 1'b0;
    logic [3:0]  hit_mask = 4'b0000;
    logic [39:0] bulletX, bulletY;
    logic [3:0]  bullet_active, bullet_dir;
`ifdef PBULLET_STATS_EN
    logic [15:0] shots_fired;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    player_bullet #(.NUM_BULLETS(4)) dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .play          (play),
        .keycode       (keycode),
        .playerX       (playerX),
        .playerY       (playerY),
        .direction     (direction),
        .scroll        (scroll),
        .hit_mask      (hit_mask),
        .bulletX       (bulletX),
        .bulletY       (bulletY),
        .bullet_active (bullet_active),
        .bullet_dir    (bullet_dir)
`ifdef PBULLET_STATS_EN
        ,
        .shots_fired   (shots_fired)
`endif
    );

    always #5 frame_clk = ~frame_clk;

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; play = 1'b0; keycode = 8'h00; scroll = 1'b0; hit_mask = 4'b0000;
        direction = 1'b1; playerX = 10'd100; playerY = 10'd200;
        step();
        Reset = 1'b0; play = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cmp_cnt++; if (bullet_active !== 4'b0000) begin err_cnt++; $display("FAIL reset_active got %b exp 0000", bullet_active); end
        cmp_cnt++; if (bulletX !== 40'd0) begin err_cnt++; $display("FAIL reset_x got %h exp 0", bulletX); end
        cmp_cnt++; if (bulletY !== 40'd0) begin err_cnt++; $display("FAIL reset_y got %h exp 0", bulletY); end
        cmp_cnt++; if (bullet_dir !== 4'b0000) begin err_cnt++; $display("FAIL reset_dir got %b exp 0000", bullet_dir); end
`ifdef PBULLET_STATS_EN
        cmp_cnt++; if (shots_fired !== 16'd0) begin err_cnt++; $display("FAIL reset_shots got %0d exp 0", shots_fired); end
`endif
    endtask

    task automatic test_single_fire();
        do_reset();
        keycode = 8'h0D;
        step();
        keycode = 8'h00;
        cmp_cnt++; if (bullet_active !== 4'b0001) begin err_cnt++; $display("FAIL spawn_mask got %b exp 0001", bullet_active); end
        cmp_cnt++; if (bulletX[9:0] !== 10'd120) begin err_cnt++; $display("FAIL spawn_x got %0d exp 120", bulletX[9:0]); end
        cmp_cnt++; if (bulletY[9:0] !== 10'd212) begin err_cnt++; $display("FAIL spawn_y got %0d exp 212", bulletY[9:0]); end
        cmp_cnt++; if (bullet_dir[0] !== 1'b1) begin err_cnt++; $display("FAIL spawn_dir got %b exp 1", bullet_dir[0]); end
        step();
        cmp_cnt++; if (bulletX[9:0] !== 10'd128) begin err_cnt++; $display("FAIL move_x got %0d exp 128", bulletX[9:0]); end
        keycode = 8'h0D;
        for (int i = 0; i < 9; i++) step();
        cmp_cnt++; if (bullet_active !== 4'b0001) begin err_cnt++; $display("FAIL cooldown_block got %b exp 0001", bullet_active); end
        step();
        cmp_cnt++; if (bullet_active !== 4'b0011) begin err_cnt++; $display("FAIL cooldown_expire got %b exp 0011", bullet_active); end
        cmp_cnt++; if (bulletX[9:0] !== 10'd208) begin err_cnt++; $display("FAIL slot0_x_f11 got %0d exp 208", bulletX[9:0]); end
        cmp_cnt++; if (bulletX[19:10] !== 10'd120) begin err_cnt++; $display("FAIL slot1_x got %0d exp 120", bulletX[19:10]); end
    endtask

    task automatic test_autofire();
        do_reset();
        keycode = 8'h0D;
        for (int f = 0; f <= 46; f++) begin
            hit_mask = (f == 45) ? 4'b0001 : 4'b0000;
            step();
            if (f == 10) begin
                cmp_cnt++; if (bullet_active !== 4'b0001) begin err_cnt++; $display("FAIL auto_f10 got %b exp 0001", bullet_active); end
            end
            if (f == 11) begin
                cmp_cnt++; if (bullet_active !== 4'b0011) begin err_cnt++; $display("FAIL auto_f11 got %b exp 0011", bullet_active); end
            end
            if (f == 22) begin
                cmp_cnt++; if (bullet_active !== 4'b0111) begin err_cnt++; $display("FAIL auto_f22 got %b exp 0111", bullet_active); end
            end
            if (f == 33) begin
                cmp_cnt++; if (bullet_active !== 4'b1111) begin err_cnt++; $display("FAIL auto_f33 got %b exp 1111", bullet_active); end
                cmp_cnt++; if (bulletX[39:30] !== 10'd120) begin err_cnt++; $display("FAIL auto_x3_f33 got %0d exp 120", bulletX[39:30]); end
            end
            if (f == 44) begin
                cmp_cnt++; if (bullet_active !== 4'b1111) begin err_cnt++; $display("FAIL auto_f44 got %b exp 1111", bullet_active); end
                cmp_cnt++; if (bulletX[9:0] !== 10'd472) begin err_cnt++; $display("FAIL auto_x0_f44 got %0d exp 472", bulletX[9:0]); end
                cmp_cnt++; if (bulletX[39:30] !== 10'd208) begin err_cnt++; $display("FAIL auto_x3_f44 got %0d exp 208", bulletX[39:30]); end
`ifdef PBULLET_STATS_EN
                cmp_cnt++; if (shots_fired !== 16'd4) begin err_cnt++; $display("FAIL shots_f44 got %0d exp 4", shots_fired); end
`endif
            end
            if (f == 45) begin
                cmp_cnt++; if (bullet_active !== 4'b1110) begin err_cnt++; $display("FAIL auto_kill_f45 got %b exp 1110", bullet_active); end
                cmp_cnt++; if (bulletX[9:0] !== 10'd472) begin err_cnt++; $display("FAIL auto_kill_hold_x got %0d exp 472", bulletX[9:0]); end
            end
            if (f == 46) begin
                cmp_cnt++; if (bullet_active !== 4'b1111) begin err_cnt++; $display("FAIL auto_refire_f46 got %b exp 1111", bullet_active); end
                cmp_cnt++; if (bulletX[9:0] !== 10'd120) begin err_cnt++; $display("FAIL auto_refire_x got %0d exp 120", bulletX[9:0]); end
`ifdef PBULLET_STATS_EN
                cmp_cnt++; if (shots_fired !== 16'd5) begin err_cnt++; $display("FAIL shots_f46 got %0d exp 5", shots_fired); end
`endif
            end
        end
        hit_mask = 4'b0000;
        keycode  = 8'h00;
    endtask

    task automatic test_retire();
        do_reset();
        playerX = 10'd616; keycode = 8'h0D;
        step();
        keycode = 8'h00;
        cmp_cnt++; if (bulletX[9:0] !== 10'd636) begin err_cnt++; $display("FAIL edge_spawn_x got %0d exp 636", bulletX[9:0]); end
        step();
        cmp_cnt++; if (bullet_active !== 4'b0000) begin err_cnt++; $display("FAIL right_retire got %b exp 0000", bullet_active); end
        cmp_cnt++; if (bulletX[9:0] !== 10'd636) begin err_cnt++; $display("FAIL retire_hold_x got %0d exp 636", bulletX[9:0]); end

        do_reset();
        playerX = 10'd610; keycode = 8'h0D;
        step();
        keycode = 8'h00; scroll = 1'b1;
        step();
        scroll = 1'b0;
        cmp_cnt++; if (bullet_active !== 4'b0001) begin err_cnt++; $display("FAIL scroll_keep got %b exp 0001", bullet_active); end
        cmp_cnt++; if (bulletX[9:0] !== 10'd633) begin err_cnt++; $display("FAIL scroll_x got %0d exp 633", bulletX[9:0]); end

        do_reset();
        direction = 1'b0; playerX = 10'd28; keycode = 8'h0D;
        step();
        keycode = 8'h00;
        cmp_cnt++; if (bulletX[9:0] !== 10'd8 || bullet_dir[0] !== 1'b0) begin err_cnt++; $display("FAIL left_spawn got x=%0d dir=%b exp x=8 dir=0", bulletX[9:0], bullet_dir[0]); end
        step();
        cmp_cnt++; if (bullet_active !== 4'b0001 || bulletX[9:0] !== 10'd0) begin err_cnt++; $display("FAIL left_zero got act=%b x=%0d exp act=0001 x=0", bullet_active, bulletX[9:0]); end
        step();
        cmp_cnt++; if (bullet_active !== 4'b0000) begin err_cnt++; $display("FAIL left_retire got %b exp 0000", bullet_active); end
    endtask

    task automatic test_dropped_spawn();
        do_reset();
        direction = 1'b0; playerX = 10'd15; keycode = 8'h0D;
        step();
        cmp_cnt++; if (bullet_active !== 4'b0000) begin err_cnt++; $display("FAIL drop_mask got %b exp 0000", bullet_active); end
        playerX = 10'd100;
        step();
        keycode = 8'h00;
        cmp_cnt++; if (bullet_active !== 4'b0001) begin err_cnt++; $display("FAIL drop_nocd got %b exp 0001", bullet_active); end
        cmp_cnt++; if (bulletX[9:0] !== 10'd80 || bullet_dir[0] !== 1'b0) begin err_cnt++; $display("FAIL drop_refire got x=%0d dir=%b exp x=80 dir=0", bulletX[9:0], bullet_dir[0]); end
    endtask

    task automatic test_kill_fire();
        do_reset();
        keycode = 8'h0D;
        step();
        keycode = 8'h00;
        for (int i = 0; i < 10; i++) step();
        keycode = 8'h0D; hit_mask = 4'b0001;
        step();
        keycode = 8'h00; hit_mask = 4'b0000;
        cmp_cnt++; if (bullet_active !== 4'b0010) begin err_cnt++; $display("FAIL kill_fire_mask got %b exp 0010", bullet_active); end
        cmp_cnt++; if (bulletX[19:10] !== 10'd120) begin err_cnt++; $display("FAIL kill_fire_x1 got %0d exp 120", bulletX[19:10]); end
        cmp_cnt++; if (bulletX[9:0] !== 10'd200) begin err_cnt++; $display("FAIL kill_hold_x0 got %0d exp 200", bulletX[9:0]); end
        hit_mask = 4'b0100;
        step();
        hit_mask = 4'b0000;
        cmp_cnt++; if (bullet_active !== 4'b0010 || bulletX[19:10] !== 10'd128) begin err_cnt++; $display("FAIL hit_inactive got act=%b x1=%0d exp act=0010 x1=128", bullet_active, bulletX[19:10]); end
    endtask

    task automatic test_play_hold();
        do_reset();
        keycode = 8'h0D;
        step();
        keycode = 8'h00;
        step();
        play = 1'b0; keycode = 8'h0D; scroll = 1'b1; hit_mask = 4'b0001;
        for (int i = 0; i < 5; i++) step();
        cmp_cnt++; if (bullet_active !== 4'b0001 || bulletX[9:0] !== 10'd128) begin err_cnt++; $display("FAIL hold_state got act=%b x=%0d exp act=0001 x=128", bullet_active, bulletX[9:0]); end
        play = 1'b1; scroll = 1'b0; hit_mask = 4'b0000;
        for (int i = 0; i < 9; i++) step();
        cmp_cnt++; if (bullet_active !== 4'b0001 || bulletX[9:0] !== 10'd200) begin err_cnt++; $display("FAIL hold_cd got act=%b x=%0d exp act=0001 x=200", bullet_active, bulletX[9:0]); end
        step();
        cmp_cnt++; if (bullet_active !== 4'b0011) begin err_cnt++; $display("FAIL hold_cd_expire got %b exp 0011", bullet_active); end
        keycode = 8'h00;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        cmp_cnt++; if (bullet_active !== 4'b0000 || bulletX !== 40'd0 || bulletY !== 40'd0 || bullet_dir !== 4'b0000) begin err_cnt++; $display("FAIL midflight_reset got act=%b x=%h y=%h dir=%b exp all 0", bullet_active, bulletX, bulletY, bullet_dir); end
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_autofire();
        test_retire();
        test_dropped_spawn();
        test_kill_fire();
        test_play_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/player_bullet.md
Name: player_bullet

Overview:
- Player projectile pool, directly downstream of the player block. Consumes its playerX/playerY/direction/scroll outputs plus the live keycode.
- Spawns, moves, scrolls and retires up to NUM_BULLETS player bullets, one update per frame_clk.
- Publishes bullet positions and an active mask to the enemy collision logic and the sprite renderer.

Parameters:
- NUM_BULLETS, 4, pool size (1..8).
- SPEED, 8, pixels moved per frame in the bullet's direction.
- SCROLL_STEP, 5, pixels subtracted from every active bullet X on a scroll frame; matches the player scroll rate.
- COOLDOWN, 10, frames between accepted shots.
- GUN_DX, 20, horizontal spawn offset from playerX.
- GUN_DY, 12, vertical spawn offset from playerY.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- play  in  1  pool updates only while high; all state holds when low.
- keycode  in  8  current key; FIRE_KEY (8'h0D) requests a shot.
- playerX  in  10  player X, screen coordinates.
- playerY  in  10  player Y (top).
- direction  in  1  1 = facing right, 0 = facing left.
- scroll  in  1  high on frames where the world scrolls left.
- hit_mask  in  NUM_BULLETS  per-slot kill request from enemy collision.
- bulletX  out  10*NUM_BULLETS  slot i X at bits [10i+9:10i].
- bulletY  out  10*NUM_BULLETS  slot i Y, same packing.
- bullet_active  out  NUM_BULLETS  slot valid mask.
- bullet_dir  out  NUM_BULLETS  per-slot travel direction, for sprite flip.

Behaviour:
Reset:
- Synchronous; takes priority over everything.
- Clears bullet_active, bulletX, bulletY and bullet_dir to 0, cooldown counter to 0.
Each frame_clk edge with play = 1, evaluated against the state at the start of the frame:
1. Kill: any slot with hit_mask[i] = 1 becomes inactive. hit_mask on an inactive slot is ignored.
2. Move: each slot active and not killed computes nx = X ± SPEED (+ when dir = 1) and, if scroll = 1, nx -= SCROLL_STEP.
   - Arithmetic is in 12-bit signed.
   - If nx < 0 or nx > 639 the slot retires (active <- 0). Otherwise X <- nx[9:0].
   - Y never changes.
3. Fire:
   - fire_req = (keycode == FIRE_KEY) && cooldown == 0.
   - The free set is the slots inactive at the start of the frame. Slots freed by kill or retire this frame are not reusable until the next frame.
   - If fire_req and the free set is non-empty, the lowest-index free slot loads:
     - active = 1
     - dir = direction
     - X = playerX + GUN_DX if direction = 1, else playerX - GUN_DX, computed signed; if the result is < 0 the spawn is dropped.
     - Y = playerY + GUN_DY
   - The cooldown counter loads COOLDOWN on a spawn.
   - A newly spawned bullet does not move in its spawn frame.
   - A request with the pool full, or a dropped spawn, is discarded and the cooldown is not reloaded.
4. Cooldown: a counter > 0 decrements by 1 on every play frame where it was not just loaded.
Other rules:
- Holding FIRE_KEY auto-fires once every COOLDOWN+1 frames while a slot is free.
- play = 0: no kill, move, fire or cooldown change; outputs hold.
- Outputs are registered: values visible one frame_clk after the inputs that caused them.
- Inactive slots keep their last X/Y; consumers must gate on bullet_active.

Optional Feature:
- Macro PBULLET_STATS_EN.
- When defined: adds output shots_fired [15:0], which increments by 1 per accepted spawn, wraps at 16'hFFFF -> 0 and resets to 0 on Reset.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package player_pkg holds:
  - constants SCREEN_W_MAX = 639, FIRE_KEY = 8'h0D
  - typedef pbullet_t {active, dir, x[9:0], y[9:0]}
- Sub-module pbullet_slot, instantiated NUM_BULLETS times, holds one pbullet_t and performs kill/move/retire/load.
- Top level owns the priority encoder (lowest free slot), the cooldown counter, output packing and the optional stats counter.

Test Plan:
- Reset, play = 1, playerX = 100, playerY = 200, direction = 1, keycode = 0D for one frame:
  - next frame: slot0 active, X = 120, Y = 212.
  - following frame: X = 128.
  - cooldown blocks firing for 10 frames.
- keycode = 0D held 60 frames, no kills: spawns on frames 0, 11, 22, 33. The request at frame 44 is dropped (pool full, cooldown not reloaded); the next shot spawns in the first frame a slot is free.
- Bullet at X = 636, dir = 1: retires on the next frame. Same bullet with scroll = 1 at X = 630: nx = 633, stays active.
- direction = 0, playerX = 15: spawn dropped (15 - 20 < 0), no slot allocated, cooldown stays 0.
- hit_mask = 0001 on the same frame as a fire request with only slot0 active: slot0 cleared, spawn goes to slot1, not slot0.
- play = 0 for 5 frames mid-flight: X, active and cooldown unchanged. Reset asserted mid-flight: all outputs 0 next edge. With PBULLET_STATS_EN: shots_fired = 4 after the 60-frame scenario.
